// File: rtl/assoc_wb_cache_pkg.sv
// Shared types and address-field width helpers for the set-associative
// write-back cache.
package assoc_wb_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_RESPOND
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words, input int sets);
        return addr_w - off_w(words) - idx_w(sets);
    endfunction

    // Zero-width fields (one set, one way) still need a 1-bit carrier signal.
    function automatic int at_least_one(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lru_tracker.sv
// Per-set true-LRU tracking using age counters: age 0 is MRU, age WAYS-1 is LRU.
module lru_tracker
    import assoc_wb_cache_pkg::*;
#(
    parameter int SETS  = 2,
    parameter int WAYS  = 2,
    parameter int SET_W = 1,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_en,
    input  logic [SET_W-1:0] touch_set,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] age_d [SETS][WAYS];

    // Ways younger than the touched one age by one; the touched way becomes MRU.
    always_comb begin
        age_d = age_q;
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_d[touch_set][w] = '0;
                end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(WAYS - 1 - w);
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[query_set][w] == WAY_W'(WAYS - 1)) begin
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_wb_cache.sv
// Set-associative write-back, write-allocate cache with a block-wide memory
// port; one request in flight, true-LRU replacement.
module assoc_wb_cache
    import assoc_wb_cache_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 2,
    parameter int WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    read_write,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       writeData,
    output logic [DATA_W-1:0]       readData,
    output logic                    resp_valid,
    output logic                    hit,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORDS*DATA_W-1:0] mem_wdata,
    input  logic [WORDS*DATA_W-1:0] mem_rdata,
    input  logic                    mem_ready
);

    localparam int OFF_W  = off_w(WORDS);
    localparam int IDX_B  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS);
    localparam int WSEL_W = OFF_W - 2;
    localparam int SET_W  = at_least_one(IDX_B);
    localparam int WAY_W  = at_least_one($clog2(WAYS));
    localparam int WA_W   = ADDR_W - 2;

    state_e              state_q, state_d;
    logic                rw_q, rw_d;
    logic [WA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                resp_valid_q, resp_valid_d;
    logic                hit_q, hit_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     valid_d [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAYS-1:0]     dirty_d [SETS];

    logic [DATA_W-1:0]   data_mem [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];

    logic [SET_W-1:0]    req_set;
    logic [TAG_W-1:0]    req_tag;
    logic [WSEL_W-1:0]   req_word;
    logic                lookup_hit;
    logic [WAY_W-1:0]    hit_way, alloc_way, lru_way;
    logic                touch_en;
    logic [WAY_W-1:0]    touch_way;
    logic                word_we, fill_we;
    logic [WAY_W-1:0]    word_way;
    logic [WORDS*DATA_W-1:0] victim_block;
    logic [ADDR_W-1:0]   wb_addr, fill_addr;
    logic                unused_addr_bits;

    // Byte lanes are not modelled; only word addresses are kept.
    assign unused_addr_bits = ^address[1:0];

    assign req_word  = addr_q[WSEL_W-1:0];
    assign req_set   = SET_W'((addr_q >> WSEL_W) & WA_W'(SETS - 1));
    assign req_tag   = TAG_W'(addr_q >> (WSEL_W + IDX_B));
    assign fill_addr = {addr_q[WA_W-1:WSEL_W], {OFF_W{1'b0}}};
    assign wb_addr   = (ADDR_W'(tag_mem[req_set][victim_q]) << (OFF_W + IDX_B))
                     | (ADDR_W'(req_set) << OFF_W);

    lru_tracker #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch_en   (touch_en),
        .touch_set  (req_set),
        .touch_way  (touch_way),
        .query_set  (req_set),
        .victim_way (lru_way)
    );

    // Scanning downward leaves the lowest-numbered match / invalid way selected.
    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        alloc_way  = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) begin
                alloc_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim_block = '0;
        for (int w = 0; w < WORDS; w++) begin
            victim_block[w*DATA_W +: DATA_W] = data_mem[req_set][victim_q][w];
        end
    end

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        resp_valid_d = 1'b0;
        hit_d        = 1'b0;
        read_data_d  = read_data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        touch_en     = 1'b0;
        touch_way    = hit_way;
        word_we      = 1'b0;
        word_way     = hit_way;
        fill_we      = 1'b0;
        req_ready    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    rw_d    = read_write;
                    addr_d  = address[ADDR_W-1:2];
                    wdata_d = writeData;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    touch_en     = 1'b1;
                    resp_valid_d = 1'b1;
                    hit_d        = 1'b1;
                    if (rw_q) begin
                        word_we                   = 1'b1;
                        dirty_d[req_set][hit_way] = 1'b1;
                    end else begin
                        read_data_d = data_mem[req_set][hit_way][req_word];
                    end
                    state_d = S_IDLE;
                end else begin
                    victim_d = alloc_way;
                    state_d  = (valid_q[req_set][alloc_way] && dirty_q[req_set][alloc_way])
                             ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_addr;
                mem_wdata = victim_block;
                if (mem_ready) begin
                    dirty_d[req_set][victim_q] = 1'b0;
                    state_d                    = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ready) begin
                    fill_we                    = 1'b1;
                    valid_d[req_set][victim_q] = 1'b1;
                    dirty_d[req_set][victim_q] = 1'b0;
                    touch_en                   = 1'b1;
                    touch_way                  = victim_q;
                    state_d                    = S_RESPOND;
                end
            end
            S_RESPOND: begin
                resp_valid_d = 1'b1;
                word_way     = victim_q;
                if (rw_q) begin
                    word_we                    = 1'b1;
                    dirty_d[req_set][victim_q] = 1'b1;
                end else begin
                    read_data_d = data_mem[req_set][victim_q][req_word];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            read_data_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            hit_q        <= hit_d;
            read_data_q  <= read_data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Tag/data storage is not reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[req_set][victim_q] <= req_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_mem[req_set][victim_q][w] <= mem_rdata[w*DATA_W +: DATA_W];
            end
        end
        if (word_we) begin
            data_mem[req_set][word_way][req_word] <= wdata_q;
        end
    end

    assign readData   = read_data_q;
    assign resp_valid = resp_valid_q;
    assign hit        = hit_q;

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench: dut0 uses default geometry, dut1 is a 4-way single-set cache;
// each has its own behavioural block memory with programmable latency.
module tb_assoc_wb_cache;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         req_valid [2];
    logic         read_write [2];
    logic [9:0]   address [2];
    logic [31:0]  wdata [2];
    logic         req_ready [2];
    logic [31:0]  rdata [2];
    logic         resp_valid [2];
    logic         hit [2];
    logic         mem_req [2];
    logic         mem_we [2];
    logic [9:0]   mem_addr [2];
    logic [127:0] mem_wdata [2];
    logic [127:0] mem_rdata [2];
    logic         mem_ready [2];

    int           lat_cfg [2];
    int           cnt [2];
    int           ntx [2];
    logic         tx_we [2][64];
    logic [9:0]   tx_addr [2][64];
    logic [127:0] tx_wdata [2][64];
    logic [31:0]  mem [2][256];
    bit           wr [2][256];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assoc_wb_cache #(.ADDR_W(10), .DATA_W(32), .WORDS(4), .SETS(2), .WAYS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .read_write(read_write[0]), .address(address[0]), .writeData(wdata[0]),
        .readData(rdata[0]), .resp_valid(resp_valid[0]), .hit(hit[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
    );

    assoc_wb_cache #(.ADDR_W(10), .DATA_W(32), .WORDS(4), .SETS(1), .WAYS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .read_write(read_write[1]), .address(address[1]), .writeData(wdata[1]),
        .readData(rdata[1]), .resp_valid(resp_valid[1]), .hit(hit[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
    );

    // Unwritten memory words read back as 0xA000_0000 | byte address.
    function automatic logic [31:0] mem_word(input int d, input int idx);
        return wr[d][idx] ? mem[d][idx] : (32'hA000_0000 | 32'(idx * 4));
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!mem_req[d] || mem_ready[d]) begin
                cnt[d]       <= 0;
                mem_ready[d] <= 1'b0;
            end else if (cnt[d] >= lat_cfg[d]) begin
                mem_ready[d] <= 1'b1;
                if (ntx[d] < 64) begin
                    tx_we[d][ntx[d]]    <= mem_we[d];
                    tx_addr[d][ntx[d]]  <= mem_addr[d];
                    tx_wdata[d][ntx[d]] <= mem_wdata[d];
                end
                ntx[d] <= ntx[d] + 1;
                for (int w = 0; w < 4; w++) begin
                    if (mem_we[d]) begin
                        mem[d][int'(mem_addr[d][9:2]) + w] <= mem_wdata[d][w*32 +: 32];
                        wr[d][int'(mem_addr[d][9:2]) + w]  <= 1'b1;
                    end else begin
                        mem_rdata[d][w*32 +: 32] <= mem_word(d, int'(mem_addr[d][9:2]) + w);
                    end
                end
            end else begin
                cnt[d] <= cnt[d] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_req(input int d, input logic rw, input logic [9:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid[d]  = 1'b1;
        read_write[d] = rw;
        address[d]    = a;
        wdata[d]      = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d, output logic [31:0] rd, output logic h, output int lat);
        lat = 1;
        while (!resp_valid[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("resp_arrives", resp_valid[d], 1'b1);
        rd = rdata[d];
        h  = hit[d];
    endtask

    task automatic access(input int d, input logic rw, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic h, output int lat);
        start_req(d, rw, a, wd);
        wait_resp(d, rd, h, lat);
        $display("txn dut%0d %s addr=%03h wdata=%08h rdata=%08h hit=%0b lat=%0d",
                 d, rw ? "WR" : "RD", a, wd, rd, h, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        h;
        int          lat;
        int          n0;
        int          g;

        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            read_write[d] = 1'b0;
            address[d]    = '0;
            wdata[d]      = '0;
            lat_cfg[d]    = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_req_ready", req_ready[0], 1'b1);
        check("rst_resp_hit", {resp_valid[0], hit[0]}, 2'b00);
        check("rst_readData", rdata[0], 32'h0);
        check("rst_mem_ctl", {mem_req[0], mem_we[0], mem_addr[0]}, 12'h000);
        check("rst_mem_wdata", mem_wdata[0], 128'h0);
        check("rst_dut1", {req_ready[1], resp_valid[1], mem_req[1]}, 3'b100);

        // Cold read then hit in the same block
        access(0, 1'b0, 10'h000, 32'h0, rd, h, lat);
        check("cold_rd_data", rd, 32'hA000_0000);
        check("cold_rd_hit", h, 1'b0);
        check("cold_rd_ntx", ntx[0], 1);
        check("cold_rd_tx", {tx_we[0][0], tx_addr[0][0]}, {1'b0, 10'h000});
        access(0, 1'b0, 10'h004, 32'h0, rd, h, lat);
        check("hit_rd_data", rd, 32'hA000_0004);
        check("hit_rd_hit_lat", {h, 8'(lat)}, {1'b1, 8'd2});
        check("hit_no_mem", ntx[0], 1);

        // Write-allocate miss, read back, then show only that way is dirty
        do_reset();
        n0 = ntx[0];
        access(0, 1'b1, 10'h008, 32'hDEAD_BEEF, rd, h, lat);
        check("wr_miss_hit", h, 1'b0);
        access(0, 1'b0, 10'h008, 32'h0, rd, h, lat);
        check("wr_rd_data", rd, 32'hDEAD_BEEF);
        check("wr_rd_hit", h, 1'b1);
        access(0, 1'b0, 10'h020, 32'h0, rd, h, lat);
        check("fill_way1_hit", h, 1'b0);
        access(0, 1'b0, 10'h040, 32'h0, rd, h, lat);
        check("evict_dirty_ntx", ntx[0] - n0, 4);
        check("evict_dirty_wb", {tx_we[0][n0+2], tx_addr[0][n0+2]}, {1'b1, 10'h000});
        check("evict_dirty_wdata", tx_wdata[0][n0+2], 128'hA000000C_DEADBEEF_A0000004_A0000000);
        check("evict_dirty_fill", {tx_we[0][n0+3], tx_addr[0][n0+3]}, {1'b0, 10'h040});
        access(0, 1'b0, 10'h060, 32'h0, rd, h, lat);
        check("evict_clean_ntx", ntx[0] - n0, 5);
        check("evict_clean_fill", {tx_we[0][n0+4], tx_addr[0][n0+4]}, {1'b0, 10'h060});
        check("evict_clean_data", rd, 32'hA000_0060);

        // LRU ordering: write 0x000, touch 0x020, then 0x040 evicts 0x000
        do_reset();
        access(0, 1'b0, 10'h000, 32'h0, rd, h, lat);
        access(0, 1'b0, 10'h020, 32'h0, rd, h, lat);
        access(0, 1'b1, 10'h000, 32'h1234_5678, rd, h, lat);
        check("lru_wr_hit", h, 1'b1);
        access(0, 1'b0, 10'h020, 32'h0, rd, h, lat);
        check("lru_touch_hit", h, 1'b1);
        n0 = ntx[0];
        access(0, 1'b0, 10'h040, 32'h0, rd, h, lat);
        check("lru_wb_tx", {tx_we[0][n0], tx_addr[0][n0]}, {1'b1, 10'h000});
        check("lru_wb_wdata", tx_wdata[0][n0], 128'hA000000C_DEADBEEF_A0000004_12345678);
        check("lru_fill_tx", {tx_we[0][n0+1], tx_addr[0][n0+1]}, {1'b0, 10'h040});
        check("lru_rd_data_hit", {rd, h}, {32'hA000_0040, 1'b0});

        // Slow refill: outputs stable, requests ignored while busy
        lat_cfg[0] = 6;
        n0 = ntx[0];
        start_req(0, 1'b0, 10'h080, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("stall_hold", {mem_req[0], mem_we[0], mem_addr[0], req_ready[0]},
                  {1'b1, 1'b0, 10'h080, 1'b0});
            if (i == 2) begin
                req_valid[0]  = 1'b1;
                read_write[0] = 1'b1;
                address[0]    = 10'h300;
                wdata[0]      = 32'h5555_5555;
            end
            if (i == 4) req_valid[0] = 1'b0;
        end
        wait_resp(0, rd, h, lat);
        check("stall_rd", {rd, h}, {32'hA000_0080, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_extra", {resp_valid[0], req_ready[0], mem_req[0]}, 3'b010);
        end
        check("stall_ntx", ntx[0] - n0, 1);
        lat_cfg[0] = 0;

        // Reset in the middle of a write-back
        do_reset();
        access(0, 1'b1, 10'h100, 32'h1111_1111, rd, h, lat);
        access(0, 1'b1, 10'h120, 32'h2222_2222, rd, h, lat);
        lat_cfg[0] = 20;
        n0 = ntx[0];
        start_req(0, 1'b0, 10'h140, 32'h0);
        g = 0;
        while (!mem_req[0] && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("wb_start", {mem_req[0], mem_we[0], mem_addr[0]}, {1'b1, 1'b1, 10'h100});
        check("wb_wdata", mem_wdata[0], 128'hA000010C_A0000108_A0000104_11111111);
        #2 rst_n = 1'b0;
        #1 check("rst_drops_mem_req", {mem_req[0], req_ready[0]}, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        lat_cfg[0] = 0;
        check("rst_no_wb_done", ntx[0], n0);
        access(0, 1'b0, 10'h100, 32'h0, rd, h, lat);
        check("rst_reread_miss", h, 1'b0);
        check("rst_dirty_lost", rd, 32'hA000_0100);

        // 4-way single set: fifth block evicts the first
        for (int b = 0; b < 4; b++) begin
            access(1, 1'b0, 10'(b * 16), 32'h0, rd, h, lat);
            check("w4_fill_miss", h, 1'b0);
        end
        n0 = ntx[1];
        access(1, 1'b0, 10'h040, 32'h0, rd, h, lat);
        check("w4_fifth", {rd, h}, {32'hA000_0040, 1'b0});
        check("w4_fifth_tx", {ntx[1] - n0, tx_we[1][n0], tx_addr[1][n0]}, {32'd1, 1'b0, 10'h040});
        access(1, 1'b0, 10'h000, 32'h0, rd, h, lat);
        check("w4_first_misses", {rd, h}, {32'hA000_0000, 1'b0});
        access(1, 1'b0, 10'h030, 32'h0, rd, h, lat);
        check("w4_fourth_hits", {rd, h}, {32'hA000_0030, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
